// File: rtl/alu_pkg.sv
// Shared ALU definitions: logic-op encodings and the iterative unit's FSM states.
package alu_pkg;

  typedef enum logic [1:0] {
    LOGIC_AND = 2'b00,
    LOGIC_OR  = 2'b01,
    LOGIC_XOR = 2'b10,
    LOGIC_NOR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/logic_slice.sv
// Combinational W-bit bitwise op selector; one slice of the iterative logic unit.
module logic_slice
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  op_t          op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      LOGIC_AND: y = a & b;
      LOGIC_OR:  y = a | b;
      LOGIC_XOR: y = a ^ b;
      LOGIC_NOR: y = ~(a | b);
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_iter.sv
// Multi-cycle bitwise logic unit: processes SLICE bits per cycle, LSB slice first,
// with the same start/ready handshake as the multdiv unit.
module logic_unit_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_start,
  input  logic [1:0]       ctrl_op,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_zero,
  output logic             data_resultRDY,
  output logic             busy,
  output state_t           dbg_state
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

  // Handshake: ctrl_start is a one-cycle request sampled on the rising edge and
  // accepted whenever busy is low (IDLE or DONE); data_resultRDY pulses for the
  // single DONE cycle, during which data_result/data_zero are already valid.

  state_t             state, state_nxt;
  op_t                op_q;
  logic [WIDTH-1:0]   a_q, b_q, acc;
  logic [WIDTH-1:0]   acc_nxt, a_shift, b_shift;
  logic [SLICE-1:0]   slice_y;
  logic [CNT_W-1:0]   cnt;
  logic               accept, last;

  logic_slice #(.W(SLICE)) u_slice (
    .op (op_q),
    .a  (a_q[SLICE-1:0]),
    .b  (b_q[SLICE-1:0]),
    .y  (slice_y)
  );

  // New slice enters at the MSB end, so after NSLICE steps the LSB slice lands at bit 0.
  generate
    if (NSLICE == 1) begin : g_single
      assign acc_nxt = slice_y;
      assign a_shift = '0;
      assign b_shift = '0;
    end else begin : g_multi
      assign acc_nxt = {slice_y, acc[WIDTH-1:SLICE]};
      assign a_shift = a_q >> SLICE;
      assign b_shift = b_q >> SLICE;
    end
  endgenerate

  assign accept = ctrl_start && (state != RUN);
  assign last   = (state == RUN) && (cnt == LAST_CNT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ctrl_start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = ctrl_start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q        <= LOGIC_AND;
      a_q         <= '0;
      b_q         <= '0;
      acc         <= '0;
      cnt         <= '0;
      data_result <= '0;
      data_zero   <= 1'b1;
    end else if (accept) begin
      op_q <= op_t'(ctrl_op);
      a_q  <= data_operandA;
      b_q  <= data_operandB;
      acc  <= '0;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_q <= a_shift;
      b_q <= b_shift;
      acc <= acc_nxt;
      // Counter parks on the last value rather than wrapping.
      if (!last) cnt <= cnt + 1'b1;
      if (last) begin
        data_result <= acc_nxt;
        data_zero   <= (acc_nxt == '0);
      end
    end
  end

  assign data_resultRDY = (state == DONE);
  assign busy           = (state == RUN);
  assign dbg_state      = state;

endmodule

// File: tb/tb_logic_unit_iter.sv
// Directed bench for logic_unit_iter: SLICE=8 instance for the main tests, SLICE=32 for the degenerate case.
module tb_logic_unit_iter;
  import alu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start1 = 1'b0, start2 = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic [31:0] result1, result2;
  logic        zero1, zero2, rdy1, rdy2, busy1, busy2;
  state_t      st1, st2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  logic_unit_iter #(.WIDTH(32), .SLICE(8)) dut (
    .clock(clock), .reset(reset), .ctrl_start(start1), .ctrl_op(op),
    .data_operandA(a), .data_operandB(b),
    .data_result(result1), .data_zero(zero1), .data_resultRDY(rdy1),
    .busy(busy1), .dbg_state(st1)
  );

  logic_unit_iter #(.WIDTH(32), .SLICE(32)) dut_wide (
    .clock(clock), .reset(reset), .ctrl_start(start2), .ctrl_op(op),
    .data_operandA(a), .data_operandB(b),
    .data_result(result2), .data_zero(zero2), .data_resultRDY(rdy2),
    .busy(busy2), .dbg_state(st2)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic sel_rdy(input int sel);
    return sel ? rdy2 : rdy1;
  endfunction

  function automatic logic sel_busy(input int sel);
    return sel ? busy2 : busy1;
  endfunction

  function automatic logic [31:0] sel_result(input int sel);
    return sel ? result2 : result1;
  endfunction

  function automatic logic sel_zero(input int sel);
    return sel ? zero2 : zero1;
  endfunction

  // Drive a start at the next negedge; returns #1 after the sampling edge with start dropped.
  task automatic drive_start(input int sel, input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb);
    @(negedge clock);
    op = o; a = va; b = vb;
    if (sel) start2 = 1'b1; else start1 = 1'b1;
    @(posedge clock);
    #1;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  // Count edges until RDY is seen (sampled #1 after each edge); bounded.
  task automatic wait_rdy(input int sel, output int lat);
    lat = 0;
    while (lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
      if (sel_rdy(sel)) break;
    end
  endtask

  task automatic run_op(input int sel, input vec_t v, input int exp_lat);
    int lat;
    drive_start(sel, v.op, v.a, v.b);
    check({v.name, " busy after start"}, 32'(sel_busy(sel)), 32'd1);
    a = $urandom; b = $urandom; op = 2'(3 - v.op);
    wait_rdy(sel, lat);
    check({v.name, " latency"}, 32'(lat), 32'(exp_lat));
    check({v.name, " result"}, sel_result(sel), v.exp);
    check({v.name, " zero"}, 32'(sel_zero(sel)), 32'(v.exp == 32'h0));
    check({v.name, " busy in done"}, 32'(sel_busy(sel)), 32'd0);
    @(posedge clock);
    #1;
    check({v.name, " rdy one cycle"}, 32'(sel_rdy(sel)), 32'd0);
    check({v.name, " result held"}, sel_result(sel), v.exp);
  endtask

  initial begin
    int lat, pulses, first_edge;
    logic [31:0] seen;

    vecs.push_back('{2'b01, 32'h12345678, 32'h87654321, 32'h97755779, "or"});
    vecs.push_back('{2'b00, 32'h12345678, 32'h87654321, 32'h02244220, "and"});
    vecs.push_back('{2'b10, 32'h12345678, 32'h87654321, 32'h95511559, "xor"});
    vecs.push_back('{2'b11, 32'h12345678, 32'h87654321, 32'h688AA886, "nor"});
    vecs.push_back('{2'b11, 32'h0000FFFF, 32'hFFFF0000, 32'h00000000, "nor_zero"});
    vecs.push_back('{2'b01, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, "or_full"});
    vecs.push_back('{2'b10, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, "xor_self"});

    // Reset
    repeat (2) @(negedge clock);
    check("reset result", result1, 32'h0);
    check("reset zero", 32'(zero1), 32'd1);
    check("reset rdy", 32'(rdy1), 32'd0);
    check("reset busy", 32'(busy1), 32'd0);
    check("reset state", 32'(st1), 32'(IDLE));
    reset = 1'b0;

    // Per-op table
    foreach (vecs[i]) run_op(0, vecs[i], 4);

    // Start while busy, with operand changes after the start edge
    drive_start(0, 2'b01, 32'hF0F0F0F0, 32'h0F0F0F0F);
    a = 32'h00000000; b = 32'h00000000;
    pulses = 0; first_edge = 0; seen = '0;
    for (int e = 1; e <= 10; e++) begin
      if (e == 2) begin
        @(negedge clock);
        op = 2'b00; a = 32'h12345678; b = 32'h00000001; start1 = 1'b1;
      end
      @(posedge clock);
      #1;
      start1 = 1'b0;
      if (rdy1) begin
        pulses++;
        if (first_edge == 0) begin first_edge = e; seen = result1; end
      end
    end
    check("busy_start pulses", 32'(pulses), 32'd1);
    check("busy_start latency", 32'(first_edge), 32'd4);
    check("busy_start result", seen, 32'hFFFFFFFF);

    // Back-to-back start in the DONE cycle
    drive_start(0, 2'b00, 32'h0000FFFF, 32'h00FF00FF);
    wait_rdy(0, lat);
    check("b2b first latency", 32'(lat), 32'd4);
    check("b2b first result", result1, 32'h000000FF);
    @(negedge clock);
    op = 2'b10; a = 32'hFFFFFFFF; b = 32'hAAAAAAAA; start1 = 1'b1;
    @(posedge clock);
    #1;
    start1 = 1'b0;
    check("b2b busy", 32'(busy1), 32'd1);
    check("b2b rdy drop", 32'(rdy1), 32'd0);
    wait_rdy(0, lat);
    check("b2b second latency", 32'(lat), 32'd4);
    check("b2b second result", result1, 32'h55555555);
    check("b2b second zero", 32'(zero1), 32'd0);

    // Reset mid-operation
    drive_start(0, 2'b01, 32'h12345678, 32'h87654321);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("midrst result", result1, 32'h0);
    check("midrst zero", 32'(zero1), 32'd1);
    check("midrst busy", 32'(busy1), 32'd0);
    check("midrst state", 32'(st1), 32'(IDLE));
    pulses = 0;
    for (int e = 0; e < 8; e++) begin
      if (e == 2) begin @(negedge clock); reset = 1'b0; end
      @(posedge clock);
      #1;
      if (rdy1) pulses++;
    end
    check("midrst no rdy", 32'(pulses), 32'd0);
    run_op(0, '{2'b01, 32'h00FF00FF, 32'hFF00FF00, 32'hFFFFFFFF, "post_rst_or"}, 4);

    // SLICE == WIDTH
    check("wide reset result", result2, 32'h0);
    run_op(1, vecs[0], 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
